ahb_mtx_l1_in_stage: RTL

//  Master-side input stage of the L1 AHB bus matrix; one instance per master port.

---
 rtl/ahb_mtx_l1_in_stage.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/ahb_mtx_l1_in_stage.sv
// Master-side input stage of the L1 AHB bus matrix. It parks an address phase
// that no output stage has granted yet, and routes the slave data-phase response back.
module ahb_mtx_l1_in_stage #(
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  HCLK,
  input  logic                  HRESETn,
  input  logic                  HSELS,
  input  logic [ADDR_WIDTH-1:0] HADDRS,
  input  logic [1:0]            HTRANSS,
  input  logic                  HWRITES,
  input  logic [2:0]            HSIZES,
  input  logic [2:0]            HBURSTS,
  input  logic [3:0]            HPROTS,
  input  logic                  HMASTLOCKS,
  input  logic                  HREADYS,
  input  logic                  addr_ack,
  input  logic                  HREADYOUTM,
  input  logic                  HRESPM,
  output logic                  req_port,
  output logic [ADDR_WIDTH-1:0] HADDRI,
  output logic [1:0]            HTRANSI,
  output logic                  HWRITEI,
  output logic [2:0]            HSIZEI,
  output logic [2:0]            HBURSTI,
  output logic [3:0]            HPROTI,
  output logic                  HMASTLOCKI,
  output logic                  HREADYOUTS,
  output logic                  HRESPS
);

  logic                  hold_vld_r;
  logic                  dp_vld_r;
  logic [ADDR_WIDTH-1:0] haddr_r;
  logic [1:0]            htrans_r;
  logic                  hwrite_r;
  logic [2:0]            hsize_r;
  logic [2:0]            hburst_r;
  logic [3:0]            hprot_r;
  logic                  hmastlock_r;

  logic                  sample_s;
  logic                  accept_s;
  logic                  capture_s;

  // Only NONSEQ/SEQ transfers seen with HREADY high are real address phases.
  assign sample_s  = HSELS & HREADYS & HTRANSS[1];
  assign req_port  = hold_vld_r | sample_s;
  assign accept_s  = addr_ack & (hold_vld_r | sample_s);
  assign capture_s = sample_s & ~addr_ack & ~hold_vld_r;

  // Hold / data-phase tracking; an accept wins over a data-phase end so bursts pipeline.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      hold_vld_r <= 1'b0;
      dp_vld_r   <= 1'b0;
    end else if (accept_s) begin
      hold_vld_r <= 1'b0;
      dp_vld_r   <= 1'b1;
    end else begin
      if (capture_s) begin
        hold_vld_r <= 1'b1;
      end
      if (dp_vld_r && HREADYOUTM) begin
        dp_vld_r <= 1'b0;
      end
    end
  end

  // Held address-phase copy, loaded only when an ungranted transfer must be parked.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      haddr_r     <= {ADDR_WIDTH{1'b0}};
      htrans_r    <= 2'b00;
      hwrite_r    <= 1'b0;
      hsize_r     <= 3'b000;
      hburst_r    <= 3'b000;
      hprot_r     <= 4'b0000;
      hmastlock_r <= 1'b0;
    end else if (capture_s) begin
      haddr_r     <= HADDRS;
      htrans_r    <= HTRANSS;
      hwrite_r    <= HWRITES;
      hsize_r     <= HSIZES;
      hburst_r    <= HBURSTS;
      hprot_r     <= HPROTS;
      hmastlock_r <= HMASTLOCKS;
    end else begin
      haddr_r     <= haddr_r;
      htrans_r    <= htrans_r;
      hwrite_r    <= hwrite_r;
      hsize_r     <= hsize_r;
      hburst_r    <= hburst_r;
      hprot_r     <= hprot_r;
      hmastlock_r <= hmastlock_r;
    end
  end

  // Address-phase source select: parked copy while holding, live master otherwise.
  always_comb begin
    HADDRI     = HADDRS;
    HTRANSI    = HTRANSS;
    HWRITEI    = HWRITES;
    HSIZEI     = HSIZES;
    HBURSTI    = HBURSTS;
    HPROTI     = HPROTS;
    HMASTLOCKI = HMASTLOCKS;
    if (hold_vld_r) begin
      HADDRI     = haddr_r;
      HTRANSI    = htrans_r;
      HWRITEI    = hwrite_r;
      HSIZEI     = hsize_r;
      HBURSTI    = hburst_r;
      HPROTI     = hprot_r;
      HMASTLOCKI = hmastlock_r;
    end else begin
      HADDRI     = HADDRS;
      HTRANSI    = HTRANSS;
      HWRITEI    = HWRITES;
      HSIZEI     = HSIZES;
      HBURSTI    = HBURSTS;
      HPROTI     = HPROTS;
      HMASTLOCKI = HMASTLOCKS;
    end
  end

  // Response to the master: stall while holding, mirror the slave during a data phase.
  always_comb begin
    HREADYOUTS = 1'b1;
    HRESPS     = 1'b0;
    if (hold_vld_r) begin
      HREADYOUTS = 1'b0;
      HRESPS     = 1'b0;
    end else if (dp_vld_r) begin
      HREADYOUTS = HREADYOUTM;
      HRESPS     = HRESPM;
    end else begin
      HREADYOUTS = 1'b1;
      HRESPS     = 1'b0;
    end
  end

endmodule
